// File: rtl/fifo_pkg.sv
// Shared definitions for the single-clock FIFO and the blocks that sit on its
// read and write sides.
//   FIFO_WIDTH      default data word width
//   FIFO_ADDR_WIDTH default FIFO address width (fillcount is one bit wider)
//   word_t          one data word at the default width
//   fillcount_t     FIFO occupancy at the default address width
package fifo_pkg;

  localparam int FIFO_WIDTH      = 8;
  localparam int FIFO_ADDR_WIDTH = 3;

  typedef logic [FIFO_WIDTH-1:0]    word_t;
  typedef logic [FIFO_ADDR_WIDTH:0] fillcount_t;

endpackage

// File: rtl/fifo_stream_reader_if.sv
// Word stream leaving the FIFO reader.
//   out_data   head word presented by the producer
//   out_valid  producer has a word on out_data
//   out_ready  consumer accepts out_data this cycle
//
// Handshake: a word transfers on a rising edge where out_valid and out_ready
// are both 1. While out_valid=1 and out_ready=0 the producer holds out_data
// and out_valid unchanged. out_valid never depends on out_ready, while
// out_ready may depend on out_valid.
interface fifo_stream_reader_if #(
  parameter int WIDTH = fifo_pkg::FIFO_WIDTH
) ();

  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);

endinterface

// File: rtl/skid_buffer.sv
// Small circular buffer holding words that were read from the FIFO but not
// yet accepted downstream.
//   clk, reset  clock, asynchronous active-low reset
//   clear       synchronous discard of every buffered word
//   wr_en       write wr_data at the write pointer
//   rd_en       retire the word at the read pointer
//   rd_data     word at the read pointer, straight from the register array
//   occupancy   number of words held (0..BUF_DEPTH)
module skid_buffer
  import fifo_pkg::*;
#(
  parameter  int WIDTH     = FIFO_WIDTH,
  parameter  int BUF_DEPTH = 2,
  localparam int PW        = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1,
  localparam int OW        = $clog2(BUF_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic [OW-1:0]    occupancy
);

  logic [WIDTH-1:0] mem [BUF_DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  // Pointers wrap at BUF_DEPTH, which need not be a power of two.
  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= bump(wr_ptr);
      end
      if (rd_en) rd_ptr <= bump(rd_ptr);
      // Simultaneous write and read leaves occupancy unchanged.
      case ({wr_en, rd_en})
        2'b10:   occupancy <= occupancy + OW'(1);
        2'b01:   occupancy <= occupancy - OW'(1);
        default: ;
      endcase
    end
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains the read side of the single-clock FIFO and presents the words as a
// valid/ready stream, with a skid buffer absorbing consumer backpressure.
//   clk, reset      clock, asynchronous active-low reset
//   enable          allow new FIFO reads (buffered words drain regardless)
//   flush           synchronous discard of buffered and in-flight words
//   fifo_fillcount  FIFO occupancy, combinational from the FIFO pointers
//   fifo_data       FIFO data_out, valid the cycle after an accepted get
//   fifo_get        read strobe to the FIFO
//   strm            output stream (out_data / out_valid / out_ready)
//   word_count      words delivered on the stream, wraps
//   busy            buffer non-empty or a read in flight
module fifo_stream_reader
  import fifo_pkg::*;
#(
  parameter int WIDTH      = FIFO_WIDTH,
  parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH,
  parameter int BUF_DEPTH  = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  flush,
  input  logic [ADDR_WIDTH:0]   fifo_fillcount,
  input  logic [WIDTH-1:0]      fifo_data,
  output logic                  fifo_get,
  fifo_stream_reader_if.master  strm,
  output logic [CNT_WIDTH-1:0]  word_count,
  output logic                  busy
);

  localparam int OW = $clog2(BUF_DEPTH + 1);

  logic [OW-1:0] occupancy;
  logic          inflight;
  logic          pop;
  logic [OW:0]   committed;
  logic [OW:0]   room;

  assign strm.out_valid = (occupancy != '0);
  assign pop            = strm.out_valid && strm.out_ready;

  // Free space counts the word already in flight and the slot a pop frees
  // this cycle: space > 0  <=>  occupancy + inflight < BUF_DEPTH + pop.
  assign committed = {1'b0, occupancy} + (OW+1)'(inflight);
  assign room      = (OW+1)'(BUF_DEPTH) + (OW+1)'(pop);

  // Only fillcount decides whether the FIFO has data; reset gates the strobe
  // so nothing is read while the block is held in reset.
  assign fifo_get = reset && enable && !flush &&
                    (fifo_fillcount != '0) && (committed < room);

  // fifo_get is 0 during flush, so the in-flight flag clears with it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) inflight <= 1'b0;
    else        inflight <= fifo_get;
  end

  // A pop coincident with flush is still a delivered word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)   word_count <= '0;
    else if (pop) word_count <= word_count + CNT_WIDTH'(1);
  end

  skid_buffer #(
    .WIDTH     (WIDTH),
    .BUF_DEPTH (BUF_DEPTH)
  ) u_skid (
    .clk       (clk),
    .reset     (reset),
    .clear     (flush),
    .wr_en     (inflight && !flush),
    .wr_data   (fifo_data),
    .rd_en     (pop),
    .rd_data   (strm.out_data),
    .occupancy (occupancy)
  );

  assign busy = (occupancy != '0) || inflight;

endmodule
